// File: rtl/gray_step_if.sv
// Request/position bundle between a requester and gray_step_tx.
interface gray_step_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] bin_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] gray_o;
  logic [WIDTH-1:0] bin_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output bin_i, valid_i,
    input  ready_o, gray_o, bin_o, busy_o, done_o
  );

  modport slave (
    input  bin_i, valid_i,
    output ready_o, gray_o, bin_o, busy_o, done_o
  );
endinterface

// File: rtl/gray_step_tx.sv
// Walks a registered Gray-code position toward a requested binary target,
// one single-bit code change every STEP_CYCLES clocks.
module gray_step_tx #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned WRAP        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  gray_step_if.slave  bus
);

  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [WIDTH-1:0] HALF   = WIDTH'(1) << (WIDTH - 1);
  localparam logic [TW-1:0]    RELOAD = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_up_q, dir_up_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] diff_up_c;
  logic             go_up_c;

  // Direction is decided once, from the target presented at accept.
  always_comb begin
    diff_up_c = bus.bin_i - pos_q;
    if (WRAP != 0) begin
      go_up_c = (diff_up_c <= HALF);
    end else begin
      go_up_c = (bus.bin_i > pos_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      target_q <= '0;
      dir_up_q <= 1'b0;
      timer_q  <= '0;
      gray_q   <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dir_up_q <= dir_up_d;
      timer_q  <= timer_d;
      gray_q   <= gray_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          target_d = bus.bin_i;
          if (bus.bin_i == pos_q) begin
            state_d = DONE;
          end else begin
            state_d  = STEP;
            timer_d  = RELOAD;
            dir_up_d = go_up_c;
          end
        end
      end
      STEP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          pos_d = dir_up_q ? (pos_q + WIDTH'(1)) : (pos_q - WIDTH'(1));
          if (pos_d == target_q) begin
            state_d = DONE;
          end else begin
            timer_d = RELOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == STEP);
    done_d  = (state_d == DONE);
    gray_d  = pos_d ^ (pos_d >> 1);
  end

  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.gray_o  = gray_q;
  assign bus.bin_o   = pos_q;

endmodule

// File: tb/tb_gray_step_tx.sv
// Bench for gray_step_tx: three configurations checked every cycle against a
// trajectory model, plus literal expectations from hand-worked walks.
module tb_gray_step_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_step_if #(.WIDTH(4)) if0 ();
  gray_step_if #(.WIDTH(4)) if1 ();
  gray_step_if #(.WIDTH(4)) if2 ();

  gray_step_tx #(.WIDTH(4), .STEP_CYCLES(1), .WRAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gray_step_tx #(.WIDTH(4), .STEP_CYCLES(1), .WRAP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gray_step_tx #(.WIDTH(4), .STEP_CYCLES(3), .WRAP(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [3:0] bin_a [3];
  logic       valid_a [3];
  logic [3:0] gray_a [3];
  logic [3:0] pos_a [3];
  logic       ready_a [3];
  logic       busy_a [3];
  logic       done_a [3];

  assign if0.bin_i = bin_a[0];  assign if0.valid_i = valid_a[0];
  assign if1.bin_i = bin_a[1];  assign if1.valid_i = valid_a[1];
  assign if2.bin_i = bin_a[2];  assign if2.valid_i = valid_a[2];
  assign gray_a[0] = if0.gray_o; assign pos_a[0] = if0.bin_o; assign ready_a[0] = if0.ready_o;
  assign busy_a[0] = if0.busy_o; assign done_a[0] = if0.done_o;
  assign gray_a[1] = if1.gray_o; assign pos_a[1] = if1.bin_o; assign ready_a[1] = if1.ready_o;
  assign busy_a[1] = if1.busy_o; assign done_a[1] = if1.done_o;
  assign gray_a[2] = if2.gray_o; assign pos_a[2] = if2.bin_o; assign ready_a[2] = if2.ready_o;
  assign busy_a[2] = if2.busy_o; assign done_a[2] = if2.done_o;

  int sc_a [3]   = '{1, 1, 3};
  int wrap_a [3] = '{0, 1, 0};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a walk is described by start, direction, step count and elapsed
  // cycles since accept; position follows from elapsed/STEP_CYCLES.
  bit started = 1'b0;
  bit m_active [3];
  bit m_rst [3];
  int m_pos [3];
  int m_start [3];
  int m_up [3];
  int m_n [3];
  int m_t [3];
  int m_tgt [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        started   = 1'b1;
        m_active[i] = 1'b0;
        m_pos[i]    = 0;
        m_rst[i]    = 1'b1;
      end else begin
        m_rst[i] = 1'b0;
        if (!m_active[i]) begin
          if (valid_a[i]) begin
            int tgt, du, dd;
            tgt = int'(bin_a[i]);
            du  = (tgt - m_pos[i] + 16) % 16;
            dd  = (m_pos[i] - tgt + 16) % 16;
            if (wrap_a[i] != 0) m_up[i] = (du <= 8) ? 1 : 0;
            else                m_up[i] = (tgt > m_pos[i]) ? 1 : 0;
            m_n[i]      = (m_up[i] != 0) ? du : dd;
            m_start[i]  = m_pos[i];
            m_tgt[i]    = tgt;
            m_t[i]      = 0;
            m_active[i] = 1'b1;
          end
        end else begin
          m_t[i]++;
          if (m_t[i] > m_n[i] * sc_a[i]) begin
            m_active[i] = 1'b0;
            m_pos[i]    = m_tgt[i];
          end
        end
      end
    end
  end

  logic [3:0] prev_gray [3];

  // Every-cycle comparison against the model, plus single-bit change check.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        int e_pos, e_rdy, e_busy, e_done, steps;
        if (!m_active[i]) begin
          e_pos = m_pos[i]; e_rdy = 1; e_busy = 0; e_done = 0;
        end else begin
          steps = m_t[i] / sc_a[i];
          if (steps > m_n[i]) steps = m_n[i];
          e_pos  = (m_start[i] + ((m_up[i] != 0) ? steps : -steps) + 16) % 16;
          e_rdy  = 0;
          e_busy = (m_t[i] < m_n[i] * sc_a[i]) ? 1 : 0;
          e_done = (m_t[i] == m_n[i] * sc_a[i]) ? 1 : 0;
        end
        chk($sformatf("dut%0d bin_o", i), int'(pos_a[i]), e_pos);
        chk($sformatf("dut%0d gray_o", i), int'(gray_a[i]), e_pos ^ (e_pos >> 1));
        chk($sformatf("dut%0d ready_o", i), int'(ready_a[i]), e_rdy);
        chk($sformatf("dut%0d busy_o", i), int'(busy_a[i]), e_busy);
        chk($sformatf("dut%0d done_o", i), int'(done_a[i]), e_done);
        if (!m_rst[i] && gray_a[i] != prev_gray[i])
          chk($sformatf("dut%0d gray hamming", i), $countones(gray_a[i] ^ prev_gray[i]), 1);
        prev_gray[i] = gray_a[i];
      end
    end
  end

  task automatic req(input int i, input logic [3:0] v);
    @(negedge clk);
    bin_a[i]   = v;
    valid_a[i] = 1'b1;
    @(negedge clk);
    valid_a[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ready_a[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk($sformatf("dut%0d wait ready timeout", i), 0, 1);
  endtask

  logic [3:0] basic_seq [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
  logic [3:0] wrap_seq  [3] = '{4'b0000, 4'b1000, 4'b1001};
  logic [3:0] pace_seq  [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bin_a[i]   = 4'd5;
      valid_a[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset gray", int'(gray_a[0]), 0);
    chk("reset ready", int'(ready_a[0]), 1);
    chk("reset done", int'(done_a[0]), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) valid_a[i] = 1'b0;

    // Basic walk 0 -> 5.
    req(0, 4'd5);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("basic step%0d gray", j + 1), int'(gray_a[0]), int'(basic_seq[j]));
    end
    chk("basic done", int'(done_a[0]), 1);
    @(negedge clk);
    chk("basic ready back", int'(ready_a[0]), 1);

    // Zero-step request at pos 5.
    req(0, 4'd5);
    chk("zero done", int'(done_a[0]), 1);
    chk("zero gray", int'(gray_a[0]), 'b0111);
    @(negedge clk);
    chk("zero ready back", int'(ready_a[0]), 1);

    // Linear long way 1 -> 14.
    req(0, 4'd1);
    wait_idle(0);
    req(0, 4'd14);
    wait_idle(0);
    chk("linear end gray", int'(gray_a[0]), 'b1001);

    // Wrapping short way 1 -> 14, then tie 0 -> 8.
    req(1, 4'd1);
    wait_idle(1);
    req(1, 4'd14);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("wrap step%0d gray", j + 1), int'(gray_a[1]), int'(wrap_seq[j]));
    end
    wait_idle(1);
    req(1, 4'd0);
    wait_idle(1);
    req(1, 4'd8);
    @(negedge clk);
    chk("tie first step up", int'(pos_a[1]), 1);
    wait_idle(1);
    chk("tie end", int'(pos_a[1]), 8);

    // Paced walk 0 -> 2 with a competing request held during the walk.
    @(negedge clk);
    bin_a[2]   = 4'd2;
    valid_a[2] = 1'b1;
    @(negedge clk);
    bin_a[2] = 4'd9;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      chk($sformatf("pace t%0d gray", t), int'(gray_a[2]), int'(pace_seq[t-1]));
    end
    chk("pace done", int'(done_a[2]), 1);
    valid_a[2] = 1'b0;
    @(negedge clk);
    chk("pace final bin", int'(pos_a[2]), 2);
    chk("pace ready back", int'(ready_a[2]), 1);

    // Reset two steps into a walk 14 -> 7.
    req(0, 4'd7);
    repeat (2) @(negedge clk);
    chk("midwalk pos before reset", int'(pos_a[0]), 12);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwalk reset gray", int'(gray_a[0]), 0);
    chk("midwalk reset ready", int'(ready_a[0]), 1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no done after reset", int'(done_a[0]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
